// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply MAC scheduler.
// Provides the FSM state enum, width defaults and the product issue schedule.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FLUSH,
        EMIT
    } state_t;

    localparam int DATA_W_DEF   = 8;
    localparam int ACC_W_DEF    = 16;
    localparam int NUM_PRODUCTS = 8;
    localparam int NUM_RESULTS  = 4;
    localparam int K_W          = 3;

    // 2-bit element index per product k, k=7 in the MSBs.
    // C00: A0B0+A1B2, C01: A0B1+A1B3,
    // C10: A2B0+A3B2, C11: A2B1+A3B3.
    localparam logic [15:0] SCHED_A = {
        2'd3, 2'd2, 2'd3, 2'd2,
        2'd1, 2'd0, 2'd1, 2'd0
    };
    localparam logic [15:0] SCHED_B = {
        2'd3, 2'd1, 2'd2, 2'd0,
        2'd3, 2'd1, 2'd2, 2'd0
    };

    function automatic logic [1:0] sched_a(
        input logic [K_W-1:0] k
    );
        return SCHED_A[2*k +: 2];
    endfunction

    function automatic logic [1:0] sched_b(
        input logic [K_W-1:0] k
    );
        return SCHED_B[2*k +: 2];
    endfunction

endpackage

// File: rtl/matmul_mul_pipe.sv
// MUL_LAT-stage registered multiplier carrying a valid tag and product index.
// Ports: clk, rst, in_vld/in_k/in_a/in_b, out_vld/out_k/out_p, pend (work left behind exit stage).
module matmul_mul_pipe
    import matmul_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [K_W-1:0]        in_k,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    output logic                  out_vld,
    output logic [K_W-1:0]        out_k,
    output logic [2*DATA_W-1:0]   out_p,
    output logic                  pend
);

    localparam int PW = 2 * DATA_W;

    logic [MUL_LAT-1:0] vld_q;
    logic [K_W-1:0]     k_q [MUL_LAT];
    logic [PW-1:0]      p_q [MUL_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        k_q[0] <= in_k;
        p_q[0] <= PW'(in_a) * PW'(in_b);
        for (int i = 1; i < MUL_LAT; i++) begin
            k_q[i] <= k_q[i-1];
            p_q[i] <= p_q[i-1];
        end
    end

    assign out_vld = vld_q[MUL_LAT-1];
    assign out_k   = k_q[MUL_LAT-1];
    assign out_p   = p_q[MUL_LAT-1];

    // Products still upstream of the exit stage; the one in the
    // exit stage is accumulated this cycle and needs no waiting.
    if (MUL_LAT > 1) begin : g_pend
        assign pend = |vld_q[MUL_LAT-2:0];
    end else begin : g_nopend
        assign pend = 1'b0;
    end

endmodule

// File: rtl/matmul_mac_sched.sv
// 2x2 x 2x2 matrix product on one shared pipelined multiplier; streams result low bytes.
// Ports: clk, rst, start, a_in, b_in, busy, done, c_out, res_valid/res_byte/res_ready, ovf (MATMUL_OVF_EN only).
module matmul_mac_sched
    import matmul_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MUL_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [4*DATA_W-1:0]           a_in,
    input  logic [4*DATA_W-1:0]           b_in,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_RESULTS*ACC_W-1:0]  c_out,
    output logic                          res_valid,
    output logic [7:0]                    res_byte,
`ifdef MATMUL_OVF_EN
    output logic [NUM_RESULTS-1:0]        ovf,
`endif
    input  logic                          res_ready
);

`ifdef MATMUL_OVF_EN
    localparam int AW = ACC_W + 1;
`else
    localparam int AW = ACC_W;
`endif

    state_t state_q, state_d;

    logic [K_W-1:0]      k_q;
    logic [1:0]          idx_q;
    logic [4*DATA_W-1:0] a_q, b_q;
    logic [AW-1:0]       acc [NUM_RESULTS];
    logic                done_q;

    logic                iss_vld;
    logic [DATA_W-1:0]   iss_a, iss_b;
    logic                ex_vld;
    logic [K_W-1:0]      ex_k;
    logic [2*DATA_W-1:0] ex_p;
    logic                pend;
    logic [1:0]          ex_r;
    logic [AW-1:0]       acc_nxt;
    logic                acc_start;
    logic                emit_ack;

    assign acc_start = (state_q == IDLE) && start;
    assign res_valid = (state_q == EMIT);
    assign emit_ack  = res_valid && res_ready;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    assign iss_vld = (state_q == ISSUE);
    assign iss_a   = a_q[DATA_W*sched_a(k_q) +: DATA_W];
    assign iss_b   = b_q[DATA_W*sched_b(k_q) +: DATA_W];

    matmul_mul_pipe #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (iss_vld),
        .in_k    (k_q),
        .in_a    (iss_a),
        .in_b    (iss_b),
        .out_vld (ex_vld),
        .out_k   (ex_k),
        .out_p   (ex_p),
        .pend    (pend)
    );

    // Even k opens a result, odd k closes it.
    assign ex_r = ex_k[2:1];

    always_comb begin
        acc_nxt = AW'(ex_p);
        if (ex_k[0]) begin
            acc_nxt = acc[ex_r] + AW'(ex_p);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                if (k_q == K_W'(NUM_PRODUCTS - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!pend) state_d = EMIT;
            end
            EMIT: begin
                if (res_ready && idx_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MATMUL_OVF_EN
    logic [NUM_RESULTS-1:0] ovf_q;
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            done_q <= 1'b0;
            for (int r = 0; r < NUM_RESULTS; r++) begin
                acc[r] <= '0;
            end
`ifdef MATMUL_OVF_EN
            ovf_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (acc_start) begin
                a_q   <= a_in;
                b_q   <= b_in;
                k_q   <= '0;
                idx_q <= '0;
`ifdef MATMUL_OVF_EN
                ovf_q <= '0;
`endif
            end
            if (iss_vld) begin
                k_q <= k_q + 1'b1;
            end
            if (emit_ack) begin
                idx_q <= idx_q + 1'b1;
                if (idx_q == 2'd3) done_q <= 1'b1;
            end
            if (ex_vld) begin
                acc[ex_r] <= acc_nxt;
`ifdef MATMUL_OVF_EN
                ovf_q[ex_r] <= acc_nxt[AW-1];
`endif
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RESULTS; r++) begin
            c_out[r*ACC_W +: ACC_W] = acc[r][ACC_W-1:0];
        end
    end

    assign res_byte = res_valid ? acc[idx_q][7:0] : 8'h00;

endmodule

// File: tb/tb_matmul_mac_sched.sv
// Directed bench for matmul_mac_sched at MUL_LAT 2 (main), 1 and 4.
// Table vectors plus hand sequences for backpressure, start handling and reset.
module tb_matmul_mac_sched;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] c;
        logic [31:0] bytes;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        res_ready;

    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [2:0]  rv;
    logic [7:0]  rb  [3];
    logic [63:0] c_w [3];
`ifdef MATMUL_OVF_EN
    logic [3:0]  ovf_w [3];
    logic [3:0]  exp_ovf [4];
`endif

    int nerr;
    int nchk;

    int          first_v [3];
    int          done_at [3];
    int          nacc    [3];
    logic [31:0] got     [3];
    int          held;
    logic [2:0]  busy1;

    vec_t tbl [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    matmul_mac_sched #(.MUL_LAT(2)) u_lat2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy_w[0]),
        .done      (done_w[0]),
        .c_out     (c_w[0]),
        .res_valid (rv[0]),
        .res_byte  (rb[0]),
`ifdef MATMUL_OVF_EN
        .ovf       (ovf_w[0]),
`endif
        .res_ready (res_ready)
    );

    matmul_mac_sched #(.MUL_LAT(1)) u_lat1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy_w[1]),
        .done      (done_w[1]),
        .c_out     (c_w[1]),
        .res_valid (rv[1]),
        .res_byte  (rb[1]),
`ifdef MATMUL_OVF_EN
        .ovf       (ovf_w[1]),
`endif
        .res_ready (res_ready)
    );

    matmul_mac_sched #(.MUL_LAT(4)) u_lat4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy_w[2]),
        .done      (done_w[2]),
        .c_out     (c_w[2]),
        .res_valid (rv[2]),
        .res_byte  (rb[2]),
`ifdef MATMUL_OVF_EN
        .ovf       (ovf_w[2]),
`endif
        .res_ready (res_ready)
    );

    task automatic chk(
        input string       name,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; start is sampled on the next posedge.
    task automatic drive_start(
        input logic [31:0] a,
        input logic [31:0] b
    );
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Observe cycles 1..ncyc after the start cycle at each negedge.
    task automatic monitor(
        input int ncyc,
        input int h_from,
        input int h_len,
        input int spur,
        input bit stop_done
    );
        bit fin;
        fin  = 1'b0;
        held = 0;
        busy1 = '0;
        for (int d = 0; d < 3; d++) begin
            first_v[d] = 0;
            done_at[d] = 0;
            nacc[d]    = 0;
            got[d]     = '0;
        end
        for (int n = 1; n <= ncyc && !fin; n++) begin
            @(negedge clk);
            res_ready = !(n >= h_from && n < h_from + h_len);
            if (n == spur) begin
                start = 1'b1;
                a_in  = '1;
                b_in  = '1;
            end else if (n == spur + 1) begin
                start = 1'b0;
            end
            if (n == 1) busy1 = busy_w;
            for (int d = 0; d < 3; d++) begin
                if (rv[d] && first_v[d] == 0) first_v[d] = n;
                if (rv[d] && res_ready) begin
                    if (nacc[d] < 4) got[d][8*nacc[d] +: 8] = rb[d];
                    nacc[d]++;
                end
                if (done_w[d] && done_at[d] == 0) done_at[d] = n;
            end
            if (!res_ready && rv[0] && rb[0] == 8'h16) held++;
            if (stop_done && done_at[0] != 0) fin = 1'b1;
        end
        res_ready = 1'b1;
    endtask

    task automatic chk_main(
        input string tag,
        input vec_t  v,
        input int    exp_first,
        input int    exp_done
    );
        chk({tag, " first_valid"}, 64'(first_v[0]), 64'(exp_first));
        chk({tag, " done_cycle"}, 64'(done_at[0]), 64'(exp_done));
        chk({tag, " byte_count"}, 64'(nacc[0]), 64'd4);
        chk({tag, " bytes"}, 64'(got[0]), 64'(v.bytes));
        chk({tag, " c_out"}, c_w[0], v.c);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"}, 64'(busy_w[0]), 64'd0);
        chk({tag, " done"}, 64'(done_w[0]), 64'd0);
        chk({tag, " res_valid"}, 64'(rv[0]), 64'd0);
        chk({tag, " res_byte"}, 64'(rb[0]), 64'd0);
        chk({tag, " c_out"}, c_w[0], 64'd0);
`ifdef MATMUL_OVF_EN
        chk({tag, " ovf"}, 64'(ovf_w[0]), 64'd0);
`endif
    endtask

    initial begin
        int stale;
        nerr = 0;
        nchk = 0;
        rst = 1'b1;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        res_ready = 1'b1;

        tbl[0] = '{a: 32'h04030201, b: 32'h08070605,
                   c: 64'h0032_002B_0016_0013,
                   bytes: 32'h322B1613};
        tbl[1] = '{a: 32'h01000001, b: 32'h08070605,
                   c: 64'h0008_0007_0006_0005,
                   bytes: 32'h08070605};
        tbl[2] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF,
                   c: 64'hFC02_FC02_FC02_FC02,
                   bytes: 32'h02020202};
        tbl[3] = '{a: 32'h40302010, b: 32'h04030201,
                   c: 64'h0160_00F0_00A0_0070,
                   bytes: 32'h60F0A070};
`ifdef MATMUL_OVF_EN
        exp_ovf[0] = 4'h0;
        exp_ovf[1] = 4'h0;
        exp_ovf[2] = 4'hF;
        exp_ovf[3] = 4'h0;
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset("por");

        for (int i = 0; i < 4; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            apply_reset();
            drive_start(tbl[i].a, tbl[i].b);
            monitor(22, 0, 0, 0, 1'b0);
            chk_main(t, tbl[i], 11, 15);
            chk({t, " busy_c1"}, 64'(busy1), 64'h7);
            chk({t, " l1 first"}, 64'(first_v[1]), 64'd10);
            chk({t, " l1 done"}, 64'(done_at[1]), 64'd14);
            chk({t, " l1 bytes"}, 64'(got[1]), 64'(tbl[i].bytes));
            chk({t, " l1 c_out"}, c_w[1], tbl[i].c);
            chk({t, " l4 first"}, 64'(first_v[2]), 64'd13);
            chk({t, " l4 done"}, 64'(done_at[2]), 64'd17);
            chk({t, " l4 bytes"}, 64'(got[2]), 64'(tbl[i].bytes));
            chk({t, " l4 c_out"}, c_w[2], tbl[i].c);
`ifdef MATMUL_OVF_EN
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s ovf%0d", t, d),
                    64'(ovf_w[d]), 64'(exp_ovf[i]));
            end
`endif
        end

        apply_reset();
        drive_start(tbl[0].a, tbl[0].b);
        monitor(26, 12, 5, 0, 1'b0);
        chk("bp held_cycles", 64'(held), 64'd5);
        chk_main("bp", tbl[0], 11, 20);

        apply_reset();
        drive_start(tbl[0].a, tbl[0].b);
        monitor(22, 0, 0, 4, 1'b1);
        chk_main("spur", tbl[0], 11, 15);
        drive_start(tbl[1].a, tbl[1].b);
        monitor(22, 0, 0, 0, 1'b0);
        chk_main("chain", tbl[1], 11, 15);

        apply_reset();
        drive_start(tbl[3].a, tbl[3].b);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (c_w[0] != 64'd0 || rv[0]) stale++;
        end
        chk("midrst stale", 64'(stale), 64'd0);
        drive_start(tbl[1].a, tbl[1].b);
        monitor(22, 0, 0, 0, 1'b0);
        chk_main("postrst", tbl[1], 11, 15);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
